sa_host_driver: RTL and testbench

SA_HOST_DRIVER -- requirements
Module: sa_host_driver

---
 rtl/sa_host_driver.sv | 139 +++++++++++++
 tb/tb_sa_host_driver.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_host_driver.sv
// Host-side driver for a systolic array: streams operand words into the array input FIFO
// and collects result words from its output FIFO. Optional DRAIN watchdog: SA_DRV_TIMEOUT_EN.
module sa_host_driver #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int BUS_WIDTH = 2*DIN_WIDTH*N,
  parameter int BUF_DEPTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic                         op_we,
  input  logic [$clog2(BUF_DEPTH)-1:0] op_addr,
  input  logic [BUS_WIDTH-1:0]         op_wdata,
  input  logic                         start,
  input  logic [$clog2(BUF_DEPTH):0]   job_len,
  input  logic [$clog2(BUF_DEPTH):0]   res_len,
  input  logic [$clog2(BUF_DEPTH)-1:0] res_addr,
  output logic [BUS_WIDTH-1:0]         res_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic                         wr_fifo,
  output logic [BUS_WIDTH-1:0]         din,
  input  logic                         in_fifo_full,
  output logic                         rd_fifo,
  input  logic [BUS_WIDTH-1:0]         dout,
  input  logic                         out_fifo_empty
);
  localparam int AW = $clog2(BUF_DEPTH);
  typedef logic [AW:0] len_t;
  localparam len_t DEPTH = len_t'(BUF_DEPTH);

  // Packed word carries A elements low and B elements high, so it must hold both vectors.
  if (BUS_WIDTH < 2*DIN_WIDTH*N || (1 << AW) != BUF_DEPTH) begin : g_bad_cfg
    $error("sa_host_driver: BUS_WIDTH too narrow or BUF_DEPTH not a power of 2");
  end

  typedef enum logic [1:0] {IDLE, PUSH, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [BUS_WIDTH-1:0] operand [BUF_DEPTH];
  logic [BUS_WIDTH-1:0] result  [BUF_DEPTH];

  len_t job_len_q, res_len_q, push_cnt, rd_cnt, pop_cnt;
  logic rd_pend;
  logic accept, len_bad, last_push, last_pop, timeout;

  assign accept    = (state == IDLE) && start;
  assign len_bad   = (job_len == '0) || (job_len > DEPTH);
  assign last_push = wr_fifo && (push_cnt == job_len_q - len_t'(1));
  assign last_pop  = rd_pend && (pop_cnt == res_len_q - len_t'(1));

`ifdef SA_DRV_TIMEOUT_EN
  logic [15:0] wd_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                         wd_cnt <= '0;
    else if (state != DRAIN || rd_pend) wd_cnt <= '0;
    else if (out_fifo_empty)            wd_cnt <= wd_cnt + 16'd1;
  end

  // Fires on the cycle whose increment would bring the count to 65535.
  assign timeout = (state == DRAIN) && !rd_pend && out_fifo_empty && (wd_cnt == 16'hFFFE);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = len_bad ? DONE : PUSH;
      PUSH:    if (last_push) state_nxt = (res_len_q == '0) ? DONE : DRAIN;
      DRAIN:   if (last_pop || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_fifo = 1'b0;
    rd_fifo = 1'b0;
    din     = '0;
    unique case (state)
      PUSH: begin
        busy    = 1'b1;
        wr_fifo = !in_fifo_full;
        if (!in_fifo_full) din = operand[push_cnt[AW-1:0]];
      end
      DRAIN: begin
        busy    = 1'b1;
        rd_fifo = !out_fifo_empty && (rd_cnt < res_len_q);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      job_len_q <= '0;
      res_len_q <= '0;
      push_cnt  <= '0;
      rd_cnt    <= '0;
      pop_cnt   <= '0;
      rd_pend   <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      job_len_q <= job_len;
      res_len_q <= res_len;
      push_cnt  <= '0;
      rd_cnt    <= '0;
      pop_cnt   <= '0;
      rd_pend   <= 1'b0;
      err       <= len_bad;
    end else begin
      if (wr_fifo) push_cnt <= push_cnt + len_t'(1);
      if (rd_fifo) rd_cnt   <= rd_cnt + len_t'(1);
      if (rd_pend) pop_cnt  <= pop_cnt + len_t'(1);
      // Array output is registered: the word for a read arrives on the following cycle.
      rd_pend <= rd_fifo;
      if (timeout) err <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (op_we && state != PUSH) operand[op_addr] <= op_wdata;
    if (rd_pend) result[pop_cnt[AW-1:0]] <= dout;
  end

  assign res_rdata = result[res_addr];

endmodule

// File: tb/tb_sa_host_driver.sv
// Scoreboard bench for sa_host_driver: expected FIFO writes, done/err and result words are
// queued at stimulus time and compared by a monitor; includes a small array FIFO model.
module tb_sa_host_driver;
  localparam int DW    = 8;
  localparam int NE    = 4;
  localparam int BW    = 2*DW*NE;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_we = 1'b0;
  logic [AW-1:0] op_addr = '0;
  logic [BW-1:0] op_wdata = '0;
  logic          start = 1'b0;
  logic [AW:0]   job_len = '0;
  logic [AW:0]   res_len = '0;
  logic [AW-1:0] res_addr = '0;
  logic [BW-1:0] res_rdata;
  logic          busy, done, err, wr_fifo, rd_fifo;
  logic [BW-1:0] din;
  logic          in_fifo_full = 1'b0;
  logic [BW-1:0] dout = '0;
  logic          out_fifo_empty = 1'b1;

  sa_host_driver #(.DIN_WIDTH(DW), .N(NE), .BUS_WIDTH(BW), .BUF_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .op_we(op_we), .op_addr(op_addr),
    .op_wdata(op_wdata), .start(start), .job_len(job_len), .res_len(res_len),
    .res_addr(res_addr), .res_rdata(res_rdata), .busy(busy), .done(done), .err(err),
    .wr_fifo(wr_fifo), .din(din), .in_fifo_full(in_fifo_full), .rd_fifo(rd_fifo),
    .dout(dout), .out_fifo_empty(out_fifo_empty)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_din [$];
  logic [BW-1:0] ret_q [$];
  logic          exp_err [$];
  logic [BW-1:0] opbuf [DEPTH];
  logic [BW-1:0] res_model [DEPTH];
  int wr_seen = 0;
  int stall_after = 0;
  int stall_left = 0;
  bit toggle_en = 1'b0;
  bit tog = 1'b0;
  bit hold_empty = 1'b0;
  bit rd_seen = 1'b0;

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: expected event did not occur or occurred when not allowed", name);
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  initial forever begin
    @(negedge sys_clk);
    rd_seen = 1'b0;
    if (rst_n) begin
      if (in_fifo_full) check_bit("wr_while_full", wr_fifo, 1'b0);
      if (wr_fifo) begin
        wr_seen++;
        if (exp_din.size() == 0) fail("unexpected_wr");
        else check("din", din, exp_din.pop_front());
      end
      if (rd_fifo) begin
        check_bit("rd_while_empty", out_fifo_empty, 1'b0);
        rd_seen = 1'b1;
      end
      if (done) begin
        if (exp_err.size() == 0) fail("unexpected_done");
        else check_bit("done_err", err, exp_err.pop_front());
        check_bit("busy_in_done", busy, 1'b0);
      end
    end
  end

  // Array model: registered output word one cycle after a read; full/empty status drivers.
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (rd_seen) begin
      if (ret_q.size() > 0) dout = ret_q.pop_front();
      else fail("rd_underflow");
    end
    tog = ~tog;
    out_fifo_empty = hold_empty || (ret_q.size() == 0) || (toggle_en && tog);
    if (stall_left > 0 && wr_seen >= stall_after) begin
      in_fifo_full = 1'b1;
      stall_left--;
    end else begin
      in_fifo_full = 1'b0;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic write_op(input logic [AW-1:0] a, input logic [BW-1:0] w);
    op_we = 1'b1;
    op_addr = a;
    op_wdata = w;
    step();
    op_we = 1'b0;
  endtask

  task automatic launch(input int jl, input int rl, input bit push_words, input bit exp_e);
    wr_seen = 0;
    if (push_words) for (int i = 0; i < jl; i++) exp_din.push_back(opbuf[i]);
    exp_err.push_back(exp_e);
    job_len = 5'(jl);
    res_len = 5'(rl);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic add_returns(input int n, input logic [BW-1:0] tag);
    for (int k = 0; k < n; k++) begin
      ret_q.push_back(tag + 64'(k));
      res_model[k] = tag + 64'(k);
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge sys_clk);
      seen = done;
    end
    if (!seen) fail("done_timeout");
  endtask

  task automatic check_results(input int n);
    for (int i = 0; i < n; i++) begin
      res_addr = AW'(i);
      #1;
      check("result", res_rdata, res_model[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) opbuf[i] = {4{8'(8'h10 + i), 8'(8'hA0 + i)}};

    repeat (3) @(posedge sys_clk);
    #2;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_bit("rst_wr", wr_fifo, 1'b0);
    check_bit("rst_rd", rd_fifo, 1'b0);
    check("rst_din", din, '0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) write_op(AW'(i), opbuf[i]);

    // Basic job: 4 back-to-back writes then 4 captures.
    add_returns(4, 64'hC100_0000_0000_0000);
    launch(4, 4, 1'b1, 1'b0);
    check_bit("busy_push", busy, 1'b1);
    repeat (4) step();
    check_int("writes_consecutive", wr_seen, 4);
    check_bit("busy_drain", busy, 1'b1);
    wait_done(40);
    step();
    check_results(4);

    // Back-pressure for 3 cycles after the 2nd write; operand write during PUSH is ignored.
    wr_seen = 0;
    stall_after = 2;
    stall_left = 3;
    add_returns(2, 64'hC200_0000_0000_0000);
    launch(4, 2, 1'b1, 1'b0);
    op_we = 1'b1;
    op_addr = 4'd3;
    op_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    op_we = 1'b0;
    wait_done(60);
    step();
    check_int("stall_writes", wr_seen, 4);
    check_int("stall_consumed", stall_left, 0);
    res_model[2] = 64'hC100_0000_0000_0002;
    res_model[3] = 64'hC100_0000_0000_0003;
    check_results(4);

    // Output FIFO empty every other cycle.
    toggle_en = 1'b1;
    add_returns(3, 64'hC300_0000_0000_0000);
    launch(2, 3, 1'b1, 1'b0);
    wait_done(80);
    step();
    toggle_en = 1'b0;
    check_results(4);

    // res_len=0: push only, results untouched.
    launch(2, 0, 1'b1, 1'b0);
    wait_done(20);
    step();
    check_results(4);

    // Illegal lengths.
    launch(0, 1, 1'b0, 1'b1);
    @(negedge sys_clk);
    check_bit("done_len0", done, 1'b1);
    check_bit("err_len0", err, 1'b1);
    step();
    step();
    check_bit("err_sticky", err, 1'b1);
    launch(17, 1, 1'b0, 1'b1);
    @(negedge sys_clk);
    check_bit("done_len17", done, 1'b1);
    step();
    add_returns(1, 64'hC400_0000_0000_0000);
    launch(1, 1, 1'b1, 1'b0);
    check_bit("err_cleared", err, 1'b0);
    wait_done(20);
    step();
    check_results(4);

    // Reset after 2 of 4 writes.
    launch(4, 4, 1'b1, 1'b0);
    begin
      bit reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
        step();
        reached = (wr_seen >= 2);
      end
      if (!reached) fail("two_writes_timeout");
    end
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_wr", wr_fifo, 1'b0);
    check("mid_rst_din", din, '0);
    check_bit("mid_rst_rd", rd_fifo, 1'b0);
    check_bit("mid_rst_done", done, 1'b0);
    check_bit("mid_rst_err", err, 1'b0);
    exp_din.delete();
    exp_err.delete();
    step();
    step();
    rst_n = 1'b1;
    check_results(4);
    add_returns(4, 64'hC500_0000_0000_0000);
    launch(4, 4, 1'b1, 1'b0);
    wait_done(40);
    step();
    check_results(4);

    // Output FIFO never delivers.
    hold_empty = 1'b1;
`ifdef SA_DRV_TIMEOUT_EN
    launch(1, 1, 1'b1, 1'b1);
    wait_done(70000);
    step();
`else
    launch(1, 1, 1'b1, 1'b0);
    repeat (300) step();
    check_bit("busy_stuck", busy, 1'b1);
    rst_n = 1'b0;
    exp_err.delete();
    step();
    rst_n = 1'b1;
`endif
    hold_empty = 1'b0;
    step();

    check_int("din_queue_empty", exp_din.size(), 0);
    check_int("done_queue_empty", exp_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
